// File: rtl/trafik_geri_sayim.sv
// trafik_geri_sayim: per-phase seconds countdown with BCD export and a two-digit multiplexed 7-segment display
// Build option: define GERI_SAYIM_BLINK_EN to blank the display in the second half of each of the last BLINK_SEC seconds
module trafik_geri_sayim #(
  parameter int CLK_HZ    = 24_000_000,
  parameter int RED_SEC   = 10,
  parameter int BLUE_SEC  = 2,
  parameter int GREEN_SEC = 5,
  parameter int MUX_DIV   = 24_000,
  parameter int BLINK_SEC = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [2:0] phase_led,
  output logic [7:0] sec_bcd,
  output logic       sec_valid,
  output logic       phase_change,
  output logic [6:0] seg,
  output logic [1:0] dig_sel
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int MW = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRE_HALF  = PW'(CLK_HZ / 2);
  localparam logic [MW-1:0] MUX_MAX   = MW'(MUX_DIV - 1);
  localparam logic [6:0]    BLINK_LIM = 7'(BLINK_SEC);
  localparam logic [7:0]    RED_BCD   = 8'((RED_SEC / 10) * 16 + RED_SEC % 10);
  localparam logic [7:0]    BLUE_BCD  = 8'((BLUE_SEC / 10) * 16 + BLUE_SEC % 10);
  localparam logic [7:0]    GREEN_BCD = 8'((GREEN_SEC / 10) * 16 + GREEN_SEC % 10);
  localparam logic [1:0]    S_IDLE    = 2'd0;
  localparam logic [1:0]    S_COUNT   = 2'd1;
  localparam logic [1:0]    S_EXPIRED = 2'd2;
  localparam logic [6:0]    SEG_OFF   = 7'h7F;
`ifdef GERI_SAYIM_BLINK_EN
  localparam logic BLINK_ON = 1'b1;
`else
  localparam logic BLINK_ON = 1'b0;
`endif

  logic [2:0]    r_led_q;
  logic [1:0]    r_state;
  logic [7:0]    r_rem;
  logic [PW-1:0] r_pre;
  logic [MW-1:0] r_mux;
  logic [1:0]    r_dig_sel;
  logic [6:0]    r_seg;
  logic          r_phase_change;

  logic          w_valid_code;
  logic          w_load;
  logic          w_drop;
  logic          w_pre_wrap;
  logic          w_mux_wrap;
  logic          w_units_slot;
  logic          w_blink;
  logic [7:0]    w_load_bcd;
  logic [7:0]    w_rem_dec;
  logic [7:0]    w_rem_nxt;
  logic [1:0]    w_state_nxt;
  logic [1:0]    w_dig_nxt;
  logic [PW-1:0] w_pre_nxt;
  logic [6:0]    w_rem_bin;
  logic [6:0]    w_seg_nxt;
  logic [3:0]    w_digit;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 7'h40;
      4'd1:    f_seg = 7'h79;
      4'd2:    f_seg = 7'h24;
      4'd3:    f_seg = 7'h30;
      4'd4:    f_seg = 7'h19;
      4'd5:    f_seg = 7'h12;
      4'd6:    f_seg = 7'h02;
      4'd7:    f_seg = 7'h78;
      4'd8:    f_seg = 7'h00;
      4'd9:    f_seg = 7'h10;
      default: f_seg = SEG_OFF;
    endcase
  endfunction

  assign w_valid_code = (phase_led == 3'b110) || (phase_led == 3'b101) || (phase_led == 3'b011);
  assign w_load       = (phase_led != r_led_q) && w_valid_code;
  assign w_drop       = (phase_led != r_led_q) && !w_valid_code;
  assign w_load_bcd   = (phase_led == 3'b110) ? RED_BCD : (phase_led == 3'b101) ? BLUE_BCD : GREEN_BCD;
  assign w_pre_wrap   = (r_pre == PRE_MAX);
  assign w_rem_dec    = (r_rem[3:0] == 4'd0) ? {r_rem[7:4] - 4'd1, 4'd9} : {r_rem[7:4], r_rem[3:0] - 4'd1};

  // A load always wins over a same-cycle prescaler wrap, so a fresh phase never loses its first second
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_pre_nxt   = r_pre;
    if (w_load) begin
      w_state_nxt = S_COUNT;
      w_rem_nxt   = w_load_bcd;
      w_pre_nxt   = '0;
    end else if (w_drop) begin
      w_state_nxt = S_IDLE;
      w_rem_nxt   = 8'h00;
      w_pre_nxt   = '0;
    end else if (r_state == S_COUNT) begin
      w_pre_nxt = w_pre_wrap ? '0 : r_pre + 1'b1;
      if (w_pre_wrap) begin
        w_rem_nxt   = w_rem_dec;
        w_state_nxt = (w_rem_dec == 8'h00) ? S_EXPIRED : S_COUNT;
      end
    end
  end

  // The display is decoded from next-state values so seg never lags dig_sel or the count
  assign w_mux_wrap   = (r_mux == MUX_MAX);
  assign w_dig_nxt    = w_mux_wrap ? ~r_dig_sel : r_dig_sel;
  assign w_units_slot = !w_dig_nxt[0];
  assign w_digit      = w_units_slot ? w_rem_nxt[3:0] : w_rem_nxt[7:4];
  assign w_rem_bin    = {3'b000, w_rem_nxt[7:4]} * 7'd10 + {3'b000, w_rem_nxt[3:0]};
  assign w_blink      = BLINK_ON && (w_state_nxt == S_COUNT) && (w_rem_bin != 7'd0) &&
                        (w_rem_bin <= BLINK_LIM) && (w_pre_nxt >= PRE_HALF);
  assign w_seg_nxt    = ((w_state_nxt == S_IDLE) || w_blink || (!w_units_slot && w_rem_nxt[7:4] == 4'd0)) ?
                        SEG_OFF : f_seg(w_digit);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_led_q        <= 3'b000;
      r_state        <= S_IDLE;
      r_rem          <= 8'h00;
      r_pre          <= '0;
      r_mux          <= '0;
      r_dig_sel      <= 2'b10;
      r_seg          <= SEG_OFF;
      r_phase_change <= 1'b0;
    end else begin
      r_led_q        <= phase_led;
      r_state        <= w_state_nxt;
      r_rem          <= w_rem_nxt;
      r_pre          <= w_pre_nxt;
      r_mux          <= w_mux_wrap ? '0 : r_mux + 1'b1;
      r_dig_sel      <= w_dig_nxt;
      r_seg          <= w_seg_nxt;
      r_phase_change <= w_load && !r_phase_change;
    end
  end

  assign sec_bcd      = r_rem;
  assign sec_valid    = (r_state != S_IDLE);
  assign phase_change = r_phase_change;
  assign seg          = r_seg;
  assign dig_sel      = r_dig_sel;
endmodule

// File: tb/tb_trafik_geri_sayim.sv
// tb_trafik_geri_sayim: directed vector table plus hand-written scan, idle, reset and blink sequences
module tb_trafik_geri_sayim;
  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [2:0] phase_led = 3'b000;
  logic [7:0] sec_bcd;
  logic       sec_valid;
  logic       phase_change;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  int n_checks = 0;
  int n_err    = 0;
  int n_edge   = 0;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
`ifdef GERI_SAYIM_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  typedef struct {
    logic [2:0] led;
    int         w;
    logic [7:0] bcd;
    logic       vld;
    logic       pc;
  } vec_t;

  trafik_geri_sayim #(
    .CLK_HZ(10), .RED_SEC(10), .BLUE_SEC(2), .GREEN_SEC(5), .MUX_DIV(4), .BLINK_SEC(3)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .phase_led(phase_led), .sec_bcd(sec_bcd),
    .sec_valid(sec_valid), .phase_change(phase_change), .seg(seg), .dig_sel(dig_sel)
  );

  always #5 sys_clk = ~sys_clk;

  // Edges since reset release: the expected scan slot is derived from this count
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) n_edge <= 0;
    else n_edge <= n_edge + 1;
  end

  function automatic logic [1:0] dig_exp();
    return ((n_edge / 4) % 2 == 1) ? 2'b01 : 2'b10;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    vec_t tbl[$];
    tbl.push_back(vec_t'{3'b110,  1, 8'h10, 1'b1, 1'b1});
    tbl.push_back(vec_t'{3'b110,  1, 8'h10, 1'b1, 1'b0});
    tbl.push_back(vec_t'{3'b110,  8, 8'h10, 1'b1, 1'b0});
    tbl.push_back(vec_t'{3'b110,  1, 8'h09, 1'b1, 1'b0});
    tbl.push_back(vec_t'{3'b110,  9, 8'h09, 1'b1, 1'b0});
    tbl.push_back(vec_t'{3'b110,  1, 8'h08, 1'b1, 1'b0});
    tbl.push_back(vec_t'{3'b110, 50, 8'h03, 1'b1, 1'b0});
    tbl.push_back(vec_t'{3'b110, 29, 8'h01, 1'b1, 1'b0});
    tbl.push_back(vec_t'{3'b110,  1, 8'h00, 1'b1, 1'b0});
    tbl.push_back(vec_t'{3'b110, 20, 8'h00, 1'b1, 1'b0});
    tbl.push_back(vec_t'{3'b101,  1, 8'h02, 1'b1, 1'b1});
    tbl.push_back(vec_t'{3'b101,  4, 8'h02, 1'b1, 1'b0});
    tbl.push_back(vec_t'{3'b011,  1, 8'h05, 1'b1, 1'b1});
    tbl.push_back(vec_t'{3'b011,  9, 8'h05, 1'b1, 1'b0});
    tbl.push_back(vec_t'{3'b011,  1, 8'h04, 1'b1, 1'b0});
    tbl.push_back(vec_t'{3'b101,  1, 8'h02, 1'b1, 1'b1});
    tbl.push_back(vec_t'{3'b101,  9, 8'h02, 1'b1, 1'b0});
    // Next load lands on the prescaler wrap edge: reload, no decrement
    tbl.push_back(vec_t'{3'b011,  1, 8'h05, 1'b1, 1'b1});
    tbl.push_back(vec_t'{3'b011,  9, 8'h05, 1'b1, 1'b0});
    tbl.push_back(vec_t'{3'b011,  1, 8'h04, 1'b1, 1'b0});
    tbl.push_back(vec_t'{3'b110,  1, 8'h10, 1'b1, 1'b1});
    tbl.push_back(vec_t'{3'b101,  1, 8'h02, 1'b1, 1'b0});
    tbl.push_back(vec_t'{3'b101,  1, 8'h02, 1'b1, 1'b0});
    tbl.push_back(vec_t'{3'b000,  1, 8'h00, 1'b0, 1'b0});
    tbl.push_back(vec_t'{3'b000, 15, 8'h00, 1'b0, 1'b0});
    tbl.push_back(vec_t'{3'b101,  1, 8'h02, 1'b1, 1'b1});
    tbl.push_back(vec_t'{3'b111,  1, 8'h00, 1'b0, 1'b0});
    tbl.push_back(vec_t'{3'b111,  1, 8'h00, 1'b0, 1'b0});
    tbl.push_back(vec_t'{3'b101,  1, 8'h02, 1'b1, 1'b1});
    tbl.push_back(vec_t'{3'b101, 10, 8'h01, 1'b1, 1'b0});

    tick(2);
    chk("rst_bcd", sec_bcd, 8'h00);
    chk("rst_valid", sec_valid, 1'b0);
    chk("rst_pc", phase_change, 1'b0);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dig", dig_sel, 2'b10);
    sys_rst_n = 1'b1;

    foreach (tbl[i]) begin
      phase_led = tbl[i].led;
      tick(tbl[i].w);
      chk($sformatf("v%0d_bcd", i), sec_bcd, tbl[i].bcd);
      chk($sformatf("v%0d_valid", i), sec_valid, tbl[i].vld);
      chk($sformatf("v%0d_pc", i), phase_change, tbl[i].pc);
    end

    phase_led = 3'b011;
    tick(1);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("scan05_dig%0d", i), dig_sel, dig_exp());
      chk($sformatf("scan05_seg%0d", i), seg, (dig_exp() == 2'b10) ? 7'b0010010 : 7'h7F);
      tick(1);
    end
    phase_led = 3'b110;
    tick(1);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("scan10_dig%0d", i), dig_sel, dig_exp());
      chk($sformatf("scan10_seg%0d", i), seg, (dig_exp() == 2'b10) ? 7'h40 : 7'h79);
      tick(1);
    end

    phase_led = 3'b000;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk($sformatf("idle_valid%0d", i), sec_valid, 1'b0);
      chk($sformatf("idle_seg%0d", i), seg, 7'h7F);
      chk($sformatf("idle_dig%0d", i), dig_sel, dig_exp());
    end
    phase_led = 3'b101;
    tick(1);
    chk("idle_reload_bcd", sec_bcd, 8'h02);
    chk("idle_reload_pc", phase_change, 1'b1);

    tick(3);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("arst_bcd", sec_bcd, 8'h00);
    chk("arst_valid", sec_valid, 1'b0);
    chk("arst_pc", phase_change, 1'b0);
    chk("arst_seg", seg, 7'h7F);
    chk("arst_dig", dig_sel, 2'b10);
    phase_led = 3'b110;
    tick(1);
    sys_rst_n = 1'b1;
    tick(1);
    chk("post_rst_bcd", sec_bcd, 8'h10);
    chk("post_rst_pc", phase_change, 1'b1);
    chk("post_rst_seg", seg, 7'h40);

    // Green 05: walk through 04, 03 and EXPIRED while watching the units slot
    phase_led = 3'b011;
    tick(1);
    for (int k = 1; k < 60; k++) begin
      int u;
      bit blank;
      tick(1);
      if ((k >= 10 && k < 30) || k >= 50) begin
        u = (k < 50) ? 5 - k / 10 : 0;
        blank = BLINK && k >= 20 && k < 30 && (k % 10) >= 5;
        chk($sformatf("blink_dig_k%0d", k), dig_sel, dig_exp());
        chk($sformatf("blink_seg_k%0d", k), seg, (dig_exp() == 2'b01 || blank) ? 7'h7F : seg_tab[u]);
      end
    end
    chk("expired_bcd", sec_bcd, 8'h00);
    chk("expired_valid", sec_valid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
